inflation_output_packer: RTL and testbench

- Downstream stage of the adder-tree crossbar in the map-inflation OR datapath.
- Consumes the crossbar's serialized per-pixel sums (one DATA_WIDTH word per handshake, raster order).
- Thresholds each sum to one occupancy bit and packs bits LSB-first into PACK_WIDTH-bit AXI-Stream words.
- Marks end of line (tlast) and start of frame (tuser), and pulses frame_done when the last word of a frame leaves.

---
 rtl/inflation_output_packer.sv | 158 +++++++++++++++
 tb/tb_inflation_output_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inflation_output_packer.sv
// -----------------------------------------------------------------------------
// inflation_output_packer
//
// Thresholds serialized per-pixel sums from the adder-tree crossbar to one
// occupancy bit each and packs them LSB-first into PACK_WIDTH-bit AXI-Stream
// words. Every line starts a fresh word, so the last word of a line may be
// partial; unused high bits are zero. tlast marks the last word of a line,
// tuser marks the word holding pixel (0,0). frame_done pulses for one cycle
// after the handshake of the final word of a frame.
//
// Ports
//   clk            : clock, all state on the rising edge
//   rstn           : asynchronous active-low reset
//   s_axis_tvalid  : input sum valid
//   s_axis_tdata   : unsigned per-pixel sum (DATA_WIDTH)
//   s_axis_tready  : packer accepts a sum this cycle
//   m_axis_tvalid  : packed word valid
//   m_axis_tdata   : packed occupancy bits, bit k = k-th pixel of the word
//   m_axis_tlast   : word holds the last pixel of a line
//   m_axis_tuser   : word holds pixel (0,0) of a frame
//   m_axis_tready  : downstream accepts the word
//   frame_done     : one-cycle pulse after the frame's final word handshake
// -----------------------------------------------------------------------------
module inflation_output_packer #(
    parameter int DATA_WIDTH = 32'd18,
    parameter int PACK_WIDTH = 32'd32,
    parameter int IMG_WIDTH  = 32'd64,
    parameter int IMG_HEIGHT = 32'd64,
    parameter int THRESHOLD  = 32'd1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [PACK_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  frame_done
);

    localparam int BW = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [BW-1:0]         BIT_LAST = BW'(PACK_WIDTH - 1);
    localparam logic [CW-1:0]         COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] THR      = DATA_WIDTH'(THRESHOLD);

    logic [PACK_WIDTH-1:0] acc_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [CW-1:0]         col_cnt_r;
    logic [RW-1:0]         row_cnt_r;
    logic                  first_pending_r;

    logic                  m_tvalid_r;
    logic [PACK_WIDTH-1:0] m_tdata_r;
    logic                  m_tlast_r;
    logic                  m_tuser_r;
    logic                  out_eof_r;
    logic                  frame_done_r;

    logic                  accept_s;
    logic                  pix_s;
    logic                  eol_s;
    logic                  eof_s;
    logic                  flush_s;
    logic [PACK_WIDTH-1:0] word_s;

    // The output register is free when empty or being drained this cycle.
    assign s_axis_tready = !m_tvalid_r || m_axis_tready;

    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tlast  = m_tlast_r;
    assign m_axis_tuser  = m_tuser_r;
    assign frame_done    = frame_done_r;

    // Accept/flush decode and assembly of the outgoing word.
    always_comb begin
        accept_s = s_axis_tvalid && s_axis_tready;
        pix_s    = (s_axis_tdata >= THR);
        eol_s    = (col_cnt_r == COL_LAST);
        eof_s    = eol_s && (row_cnt_r == ROW_LAST);
        flush_s  = accept_s && ((bit_cnt_r == BIT_LAST) || eol_s);
        word_s   = '0;
        // Bits below the current slot come from acc, the current slot is the
        // incoming pixel, anything above is zero padding.
        for (int k = 0; k < PACK_WIDTH; k++) begin
            if (k < int'(bit_cnt_r)) begin
                word_s[k] = acc_r[k];
            end else if (k == int'(bit_cnt_r)) begin
                word_s[k] = pix_s;
            end else begin
                word_s[k] = 1'b0;
            end
        end
    end

    // Bit accumulator and raster position counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r           <= '0;
            bit_cnt_r       <= '0;
            col_cnt_r       <= '0;
            row_cnt_r       <= '0;
            first_pending_r <= 1'b1;
        end else if (accept_s) begin
            if (flush_s) begin
                acc_r           <= '0;
                bit_cnt_r       <= '0;
                first_pending_r <= 1'b0;
            end else begin
                acc_r[bit_cnt_r] <= pix_s;
                bit_cnt_r        <= bit_cnt_r + BW'(1);
            end
            if (eol_s) begin
                col_cnt_r <= '0;
                if (row_cnt_r == ROW_LAST) begin
                    row_cnt_r       <= '0;
                    // Placed after the flush clear so end of frame re-arms tuser.
                    first_pending_r <= 1'b1;
                end else begin
                    row_cnt_r <= row_cnt_r + RW'(1);
                end
            end else begin
                col_cnt_r <= col_cnt_r + CW'(1);
            end
        end
    end

    // Output word register and frame_done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_tvalid_r   <= 1'b0;
            m_tdata_r    <= '0;
            m_tlast_r    <= 1'b0;
            m_tuser_r    <= 1'b0;
            out_eof_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (flush_s) begin
                m_tvalid_r <= 1'b1;
                m_tdata_r  <= word_s;
                m_tlast_r  <= eol_s;
                m_tuser_r  <= first_pending_r;
                out_eof_r  <= eof_s;
            end else if (m_axis_tready) begin
                m_tvalid_r <= 1'b0;
            end
            frame_done_r <= m_tvalid_r && m_axis_tready && out_eof_r;
        end
    end

endmodule

// File: tb/tb_inflation_output_packer.sv
// -----------------------------------------------------------------------------
// Testbench for inflation_output_packer (PACK_WIDTH=8, IMG_WIDTH=12,
// IMG_HEIGHT=2, THRESHOLD=2). A line-oriented reference model pushes the
// expected words into a queue as pixels are accepted; an independent monitor
// pops and compares on each output handshake and tracks frame_done.
// -----------------------------------------------------------------------------
module tb_inflation_output_packer;

    localparam int DW = 18;
    localparam int PW = 8;
    localparam int IW = 12;
    localparam int IH = 2;
    localparam int TH = 2;

    logic          clk;
    logic          rstn;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tready;
    logic          m_tvalid;
    logic [PW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_tready;
    logic          frame_done;

    inflation_output_packer #(
        .DATA_WIDTH(DW), .PACK_WIDTH(PW), .IMG_WIDTH(IW),
        .IMG_HEIGHT(IH), .THRESHOLD(TH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] data;
        logic          last;
        logic          user;
        logic          eof;
    } word_t;

    word_t exp_q[$];
    bit    line_buf[IW];
    int    m_col;
    int    m_row;
    bit    fd_exp;
    int    accepted;
    int    checks;
    int    errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_col  = 0;
        m_row  = 0;
        fd_exp = 1'b0;
    endfunction

    // Each line is cut into PW-pixel chunks starting at column 0; a chunk is
    // complete when it fills up or the line ends.
    function automatic void model_pixel(input logic [DW-1:0] sum);
        int    start;
        word_t w;
        line_buf[m_col] = (int'(sum) >= TH);
        if (((m_col + 1) % PW == 0) || (m_col == IW - 1)) begin
            start  = (m_col / PW) * PW;
            w.data = '0;
            for (int k = 0; k <= m_col - start; k++) w.data[k] = line_buf[start + k];
            w.last = (m_col == IW - 1);
            w.user = (m_row == 0) && (start == 0);
            w.eof  = w.last && (m_row == IH - 1);
            exp_q.push_back(w);
        end
        if (m_col == IW - 1) begin
            m_col = 0;
            m_row = (m_row + 1) % IH;
        end else begin
            m_col++;
        end
    endfunction

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rdy);
        @(negedge clk);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = rdy;
        #1;
        if (s_tvalid && s_tready) begin
            model_pixel(d);
            accepted++;
        end
    endtask

    function automatic logic [DW-1:0] rand_sum();
        if ($urandom_range(0, 7) < 6) return DW'($urandom_range(0, 3));
        else return DW'($urandom_range(0, 32'h3FFFF));
    endfunction

    // Monitor: pops the scoreboard on each output handshake.
    always begin : monitor
        word_t w;
        @(negedge clk);
        #2;
        if (rstn) begin
            check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", m_tdata);
                    fd_exp = 1'b0;
                end else begin
                    w = exp_q.pop_front();
                    check("tdata", {24'd0, m_tdata}, {24'd0, w.data});
                    check("tlast", {31'd0, m_tlast}, {31'd0, w.last});
                    check("tuser", {31'd0, m_tuser}, {31'd0, w.user});
                    fd_exp = w.eof;
                end
            end else begin
                fd_exp = 1'b0;
            end
            if (m_tvalid && !m_tready) check("stall_tready", {31'd0, s_tready}, 32'd0);
        end
    end

    initial begin
        int a0;
        checks   = 0;
        errors   = 0;
        accepted = 0;
        model_reset();
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tdata", {24'd0, m_tdata}, 32'd0);
        check("rst_tlast", {31'd0, m_tlast}, 32'd0);
        check("rst_tuser", {31'd0, m_tuser}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rstn = 1'b1;

        // One frame of alternating occupied/free pixels at full rate.
        a0 = accepted;
        for (int i = 0; i < IW * IH; i++) cycle(1'b1, (i % 2 == 0) ? DW'(2) : DW'(0), 1'b1);
        check("full_rate_accepts", accepted - a0, IW * IH);

        // Threshold boundary: 0x3FFFF and 2 occupied, 1 not.
        cycle(1'b1, DW'(0), 1'b1);
        cycle(1'b1, DW'(32'h3FFFF), 1'b1);
        cycle(1'b1, DW'(1), 1'b1);
        cycle(1'b1, DW'(2), 1'b1);
        for (int i = 4; i < IW; i++) cycle(1'b1, DW'(0), 1'b1);

        // Stall for five cycles right after the first word of a line.
        for (int i = 0; i < PW; i++) cycle(1'b1, DW'(3), 1'b1);
        a0 = accepted;
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(3), 1'b0);
        check("stall_no_accept", accepted - a0, 0);
        for (int i = PW; i < IW; i++) cycle(1'b1, DW'(i), 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, rand_sum(), $urandom_range(0, 3) != 0);

        // Align to frame start, then abort after 10 pixels of line 0.
        for (int i = 0; i < 200 && !(m_col == 0 && m_row == 0); i++)
            cycle(1'b1, rand_sum(), 1'b1);
        check("align_frame", m_col + m_row, 0);
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(3), 1'b1);
        @(negedge clk);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        check("arst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("arst_tdata", {24'd0, m_tdata}, 32'd0);
        check("arst_tlast", {31'd0, m_tlast}, 32'd0);
        check("arst_tuser", {31'd0, m_tuser}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < IW; i++) cycle(1'b1, DW'(0), 1'b1);
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(0, 3) != 0, rand_sum(), $urandom_range(0, 3) != 0);

        // Drain and confirm every expected word came out.
        for (int i = 0; i < 20; i++) cycle(1'b0, DW'(0), 1'b1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
